// File: rtl/debounce_pkg.sv
// Shared types and constants for the pushbutton debouncer.
//   state_e          : debounce FSM encoding (LOW, WAIT_HIGH, HIGH, WAIT_LOW)
//   MinStableCycles  : smallest legal STABLE_CYCLES value
package debounce_pkg;

  localparam int unsigned MinStableCycles = 2;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (second flop)
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton/switch debouncer. The output level only changes after the sampled
// input has held the new value for STABLE_CYCLES consecutive clock edges; any
// bounce during that window restarts the timing from scratch.
// Optional feature: define DEBOUNCE_SYNC_EN to place a two-flop synchronizer
// (sync2) in front of the FSM, adding two edges of latency.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   in       : raw bouncing input level
//   level    : registered debounced level
//   settling : registered, high while a candidate transition is being timed
module button_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic settling
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < MinStableCycles) begin : g_bad_param
    $error("button_debounce: STABLE_CYCLES must be at least 2");
  end

  logic sample;

`ifdef DEBOUNCE_SYNC_EN
  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (sample)
  );
`else
  assign sample = in;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            settling_q, settling_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOW;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      settling_q <= settling_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;

    unique case (state_q)
      LOW: begin
        if (sample) begin
          state_d = WAIT_HIGH;
          cnt_d   = CntW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sample) begin
          // A bounce discards all accumulated time.
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = HIGH;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      HIGH: begin
        if (!sample) begin
          state_d = WAIT_LOW;
          cnt_d   = CntW'(1);
        end
      end
      WAIT_LOW: begin
        if (sample) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = LOW;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase

    // Registered copy of "next state is a timing state" so settling tracks state_q.
    settling_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign level    = level_q;
  assign settling = settling_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int unsigned StableCycles = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif
  // Edges from the first edge with in at its new value until level changes.
  localparam int Lat = StableCycles + SyncLat;

  logic clk;
  logic rst;
  logic in;
  logic level;
  logic settling;

  int checks;
  int failures;

  button_debounce #(
    .STABLE_CYCLES (StableCycles)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .level    (level),
    .settling (settling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in       = 1'b0;
    steps(3);
    check_eq("rst_level", {31'b0, level}, 32'd0);
    check_eq("rst_settling", {31'b0, settling}, 32'd0);
    rst = 1'b0;

    // Idle low for 20 cycles.
    for (int e = 1; e <= 20; e++) begin
      step();
      check_eq($sformatf("idle_level_e%0d", e), {31'b0, level}, 32'd0);
      check_eq($sformatf("idle_settling_e%0d", e), {31'b0, settling}, 32'd0);
    end

    // Clean rise.
    in = 1'b1;
    for (int e = 1; e <= Lat + 1; e++) begin
      step();
      check_eq($sformatf("rise_level_e%0d", e), {31'b0, level}, (e >= Lat) ? 32'd1 : 32'd0);
      check_eq($sformatf("rise_settling_e%0d", e), {31'b0, settling},
               (e >= SyncLat + 1 && e <= Lat - 1) ? 32'd1 : 32'd0);
    end

    // Clean fall.
    in = 1'b0;
    for (int e = 1; e <= Lat + 1; e++) begin
      step();
      check_eq($sformatf("fall_level_e%0d", e), {31'b0, level}, (e >= Lat) ? 32'd0 : 32'd1);
      check_eq($sformatf("fall_settling_e%0d", e), {31'b0, settling},
               (e >= SyncLat + 1 && e <= Lat - 1) ? 32'd1 : 32'd0);
    end

    // Bouncing rise: H2 L1 H3 L1 then steady high.
    begin
      logic bounce [7];
      bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
        in = bounce[i];
        step();
        check_eq($sformatf("bounce_level_i%0d", i), {31'b0, level}, 32'd0);
      end
    end
    in = 1'b1;
    for (int e = 1; e <= Lat + 2; e++) begin
      step();
      check_eq($sformatf("bounce_final_level_e%0d", e), {31'b0, level},
               (e >= Lat) ? 32'd1 : 32'd0);
    end

    // 3-cycle low glitch leaves level high.
    in = 1'b0;
    steps(3);
    in = 1'b1;
    for (int e = 1; e <= Lat + 3; e++) begin
      step();
      check_eq($sformatf("lowglitch_level_e%0d", e), {31'b0, level}, 32'd1);
    end
    check_eq("lowglitch_settling_end", {31'b0, settling}, 32'd0);

    // Return low.
    in = 1'b0;
    steps(Lat + 2);
    check_eq("relow_level", {31'b0, level}, 32'd0);

    // 3-cycle high pulse never raises level.
    in = 1'b1;
    steps(3);
    in = 1'b0;
    for (int e = 1; e <= Lat + 3; e++) begin
      step();
      check_eq($sformatf("shortpulse_level_e%0d", e), {31'b0, level}, 32'd0);
    end
    check_eq("shortpulse_settling_end", {31'b0, settling}, 32'd0);

    // Reset while in WAIT_HIGH with cnt=2.
    in = 1'b1;
    steps(SyncLat + 2);
    check_eq("midwait_settling", {31'b0, settling}, 32'd1);
    rst = 1'b1;
    step();
    check_eq("midwait_rst_level", {31'b0, level}, 32'd0);
    check_eq("midwait_rst_settling", {31'b0, settling}, 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= Lat + 1; e++) begin
      step();
      check_eq($sformatf("postrst_level_e%0d", e), {31'b0, level}, (e >= Lat) ? 32'd1 : 32'd0);
      check_eq($sformatf("postrst_settling_e%0d", e), {31'b0, settling},
               (e >= SyncLat + 1 && e <= Lat - 1) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
